// File: rtl/usr_serial_rx_pkg.sv
//------------------------------------------------------------------------------
// Module   : usr_serial_rx_pkg
// Brief    : Shared types and constants for the serial word receiver.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package usr_serial_rx_pkg;

    // Receiver control states (PARITY is reachable only in the parity build)
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        STALL  = 2'd3
    } state_t;

    // Frame bit order as signalled by the shift-register source
    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage : usr_serial_rx_pkg

`default_nettype wire

// File: rtl/usr_serial_rx_if.sv
//------------------------------------------------------------------------------
// Module   : usr_serial_rx_if
// Brief    : Serial input stream and parallel output port of the receiver.
//            master = bit source / word consumer, slave = receiver.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface usr_serial_rx_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             sin_valid;
    logic             sin_bit;
    logic             sin_dir;
    logic             sin_abort;
    logic             sin_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             parity_err;
    logic             busy;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output sin_valid, sin_bit, sin_dir, sin_abort, dout_ready,
        input  sin_ready, dout, dout_valid, parity_err, busy, word_cnt
    );

    modport slave (
        input  sin_valid, sin_bit, sin_dir, sin_abort, dout_ready,
        output sin_ready, dout, dout_valid, parity_err, busy, word_cnt
    );

endinterface : usr_serial_rx_if

`default_nettype wire

// File: rtl/usr_rx_shifter.sv
//------------------------------------------------------------------------------
// Module   : usr_rx_shifter
// Brief    : Direction-aware accumulator and bit counter. A load starts a new
//            frame (latching the bit order), a shift appends one bit, a clear
//            empties it. o_acc_nxt is the value the next shift would produce.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module usr_rx_shifter
    import usr_serial_rx_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CNT_BITS = 3
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_clear,
    input  wire logic                i_load,
    input  wire logic                i_shift,
    input  wire logic                i_bit,
    input  wire logic                i_dir,
    output logic     [WIDTH-1:0]     o_acc,
    output logic     [WIDTH-1:0]     o_acc_nxt,
    output logic     [CNT_BITS-1:0]  o_cnt
);

    logic [WIDTH-1:0]    r_acc;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_dir;
    logic [WIDTH-1:0]    w_shifted;
    logic [WIDTH-1:0]    w_first;

    // Shift toward the MSB for MSB-first frames, toward the LSB otherwise
    always_comb begin
        w_shifted = (r_dir == DIR_MSB_FIRST) ? {r_acc[WIDTH-2:0], i_bit}
                                             : {i_bit, r_acc[WIDTH-1:1]};
        w_first   = (i_dir == DIR_MSB_FIRST) ? {{(WIDTH-1){1'b0}}, i_bit}
                                             : {i_bit, {(WIDTH-1){1'b0}}};
    end

    // Accumulator, counter and latched bit order; clear wins over shift
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_dir <= DIR_LSB_FIRST;
        end else if (i_load) begin
            r_acc <= w_first;
            r_cnt <= CNT_BITS'(1);
            r_dir <= i_dir;
        end else if (i_shift) begin
            r_acc <= w_shifted;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_acc     = r_acc;
    assign o_acc_nxt = w_shifted;
    assign o_cnt     = r_cnt;

endmodule : usr_rx_shifter

`default_nettype wire

// File: rtl/usr_serial_rx.sv
//------------------------------------------------------------------------------
// Module   : usr_serial_rx
// Brief    : Serial-to-parallel receiver for a universal shift register
//            stream (MSB or LSB first) with a one-word valid/ready output
//            holding register and a delivered-word counter.
//            Optional macro USR_SERIAL_RX_PARITY_EN adds an even-parity bit
//            after each frame and drives parity_err.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module usr_serial_rx
    import usr_serial_rx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input wire logic      clk,
    input wire logic      rst,
    usr_serial_rx_if.slave rx
);

    localparam int                  CNT_BITS = $clog2(WIDTH + 1);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_dout;
    logic                r_dout_valid;
    logic [CNT_W-1:0]    r_word_cnt;

    logic                w_accept;
    logic                w_drain;
    logic                w_room;
    logic                w_load;
    logic                w_shift;
    logic                w_clear;
    logic                w_push;
    logic [WIDTH-1:0]    w_word;
    logic [WIDTH-1:0]    w_acc;
    logic [WIDTH-1:0]    w_acc_nxt;
    logic [CNT_BITS-1:0] w_cnt;

`ifdef USR_SERIAL_RX_PARITY_EN
    logic                r_parity_err;
    logic                r_perr_pend;
    logic                w_perr;
    logic                w_perr_ld;
    logic                w_par_bad;
`endif

    assign rx.sin_ready = !rx.sin_abort && (r_state != STALL);
    assign w_accept     = rx.sin_valid && rx.sin_ready;
    assign w_drain      = r_dout_valid && rx.dout_ready;
    assign w_room       = !r_dout_valid || rx.dout_ready;

    usr_rx_shifter #(
        .WIDTH    (WIDTH),
        .CNT_BITS (CNT_BITS)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_load    (w_load),
        .i_shift   (w_shift),
        .i_bit     (rx.sin_bit),
        .i_dir     (rx.sin_dir),
        .o_acc     (w_acc),
        .o_acc_nxt (w_acc_nxt),
        .o_cnt     (w_cnt)
    );

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, shifter control and word hand-off into the holding register
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_clear     = 1'b0;
        w_push      = 1'b0;
        w_word      = w_acc;
`ifdef USR_SERIAL_RX_PARITY_EN
        w_perr      = 1'b0;
        w_perr_ld   = 1'b0;
        w_par_bad   = (^w_acc) ^ rx.sin_bit;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (rx.sin_abort) begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_accept) begin
                    w_shift = 1'b1;
                    if (w_cnt == LAST_CNT) begin
`ifdef USR_SERIAL_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        if (w_room) begin
                            w_push      = 1'b1;
                            w_word      = w_acc_nxt;
                            w_clear     = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = STALL;
                        end
`endif
                    end
                end
            end
`ifdef USR_SERIAL_RX_PARITY_EN
            PARITY: begin
                if (rx.sin_abort) begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_accept) begin
                    if (w_room) begin
                        w_push      = 1'b1;
                        w_perr      = w_par_bad;
                        w_clear     = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_perr_ld   = 1'b1;
                        w_state_nxt = STALL;
                    end
                end
            end
`endif
            STALL: begin
                // The completed word waits in the shifter until the held word leaves
                if (w_drain) begin
                    w_push      = 1'b1;
`ifdef USR_SERIAL_RX_PARITY_EN
                    w_perr      = r_perr_pend;
`endif
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_clear     = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output holding register; a push always implies room, so no word is lost
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_push) begin
            r_dout       <= w_word;
            r_dout_valid <= 1'b1;
        end else if (w_drain) begin
            r_dout_valid <= 1'b0;
        end
    end

    // Delivered-word counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else if (w_drain) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

`ifdef USR_SERIAL_RX_PARITY_EN
    // Parity flag travels with dout; a stalled word keeps its flag pending
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
            r_perr_pend  <= 1'b0;
        end else begin
            if (w_push) begin
                r_parity_err <= w_perr;
            end
            if (w_perr_ld) begin
                r_perr_pend <= w_par_bad;
            end
        end
    end

    assign rx.parity_err = r_parity_err;
`else
    assign rx.parity_err = 1'b0;
`endif

    assign rx.dout       = r_dout;
    assign rx.dout_valid = r_dout_valid;
    assign rx.busy       = (r_state != IDLE);
    assign rx.word_cnt   = r_word_cnt;

endmodule : usr_serial_rx

`default_nettype wire

// File: tb/tb_usr_serial_rx.sv
//------------------------------------------------------------------------------
// Module   : tb_usr_serial_rx
// Brief    : Directed self-checking bench for usr_serial_rx (WIDTH=4).
//            Define USR_SERIAL_RX_PARITY_EN to include the parity vectors.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_usr_serial_rx;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    usr_serial_rx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) rx_bus ();

    usr_serial_rx #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic dir, input logic b);
        rx_bus.sin_valid = 1'b1;
        rx_bus.sin_dir   = dir;
        rx_bus.sin_bit   = b;
        tick();
    endtask

    // Bits go out in order seq[3], seq[2], seq[1], seq[0]
    task automatic send_frame(input logic dir, input logic [3:0] seq);
        for (int i = 3; i >= 0; i--) begin
            send_bit(dir, seq[i]);
        end
    endtask

    task automatic idle_cycle();
        rx_bus.sin_valid = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rx_bus.sin_valid  = 1'b0;
        rx_bus.sin_bit    = 1'b0;
        rx_bus.sin_dir    = 1'b0;
        rx_bus.sin_abort  = 1'b0;
        rx_bus.dout_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_dout",       32'(rx_bus.dout),       32'h0);
        check("rst_dout_valid", 32'(rx_bus.dout_valid), 32'h0);
        check("rst_parity_err", 32'(rx_bus.parity_err), 32'h0);
        check("rst_busy",       32'(rx_bus.busy),       32'h0);
        check("rst_word_cnt",   32'(rx_bus.word_cnt),   32'h0);
        check("rst_sin_ready",  32'(rx_bus.sin_ready),  32'h1);

        // 1: MSB first 1,0,1,0 -> 1010, one-cycle valid pulse
        rx_bus.dout_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        check("t1_busy_mid", 32'(rx_bus.busy), 32'h1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        check("t1_no_early_valid", 32'(rx_bus.dout_valid), 32'h0);
        send_bit(1'b1, 1'b0);
        check("t1_dout",       32'(rx_bus.dout),       32'hA);
        check("t1_valid",      32'(rx_bus.dout_valid), 32'h1);
        check("t1_parity_err", 32'(rx_bus.parity_err), 32'h0);
        idle_cycle();
        check("t1_valid_drop", 32'(rx_bus.dout_valid), 32'h0);
        check("t1_word_cnt",   32'(rx_bus.word_cnt),   32'h1);

        // 2: LSB first 0,0,1,1 -> 1100, then MSB first 1,1,0,0 -> 1100 with no gap
        send_frame(1'b0, 4'b0011);
        check("t2a_dout",  32'(rx_bus.dout),       32'hC);
        check("t2a_valid", 32'(rx_bus.dout_valid), 32'h1);
        check("t2a_idle",  32'(rx_bus.busy),       32'h0);
        send_frame(1'b1, 4'b1100);
        check("t2b_dout",  32'(rx_bus.dout),       32'hC);
        check("t2b_valid", 32'(rx_bus.dout_valid), 32'h1);
        idle_cycle();
        check("t2_word_cnt", 32'(rx_bus.word_cnt), 32'h3);

        // 3: consumer stalls, second frame waits in STALL
        rx_bus.dout_ready = 1'b0;
        send_frame(1'b1, 4'b1010);
        check("t3_first_dout", 32'(rx_bus.dout), 32'hA);
        send_frame(1'b1, 4'b0101);
        check("t3_stall_ready", 32'(rx_bus.sin_ready), 32'h0);
        check("t3_stall_busy",  32'(rx_bus.busy),      32'h1);
        idle_cycle();
        check("t3_hold_dout",  32'(rx_bus.dout),       32'hA);
        check("t3_hold_valid", 32'(rx_bus.dout_valid), 32'h1);
        check("t3_hold_cnt",   32'(rx_bus.word_cnt),   32'h3);
        rx_bus.dout_ready = 1'b1;
        tick();
        check("t3_second_dout",  32'(rx_bus.dout),       32'h5);
        check("t3_second_valid", 32'(rx_bus.dout_valid), 32'h1);
        check("t3_cnt_one",      32'(rx_bus.word_cnt),   32'h4);
        check("t3_ready_back",   32'(rx_bus.sin_ready),  32'h1);
        tick();
        check("t3_valid_drop", 32'(rx_bus.dout_valid), 32'h0);
        check("t3_cnt_two",    32'(rx_bus.word_cnt),   32'h5);

        // 4: abort after two bits, offered bit ignored, then 0,1,1,0 -> 0110
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        rx_bus.sin_abort = 1'b1;
        rx_bus.sin_valid = 1'b1;
        rx_bus.sin_bit   = 1'b1;
        #1;
        check("t4_abort_ready", 32'(rx_bus.sin_ready), 32'h0);
        tick();
        check("t4_abort_busy", 32'(rx_bus.busy), 32'h0);
        rx_bus.sin_abort = 1'b0;
        send_frame(1'b1, 4'b0110);
        check("t4_dout",  32'(rx_bus.dout),       32'h6);
        check("t4_valid", 32'(rx_bus.dout_valid), 32'h1);
        idle_cycle();
        check("t4_word_cnt", 32'(rx_bus.word_cnt), 32'h6);

        // 5: reset mid-frame with a held word, then a clean frame 0011
        rx_bus.dout_ready = 1'b0;
        send_frame(1'b1, 4'b0011);
        check("t5_held_valid", 32'(rx_bus.dout_valid), 32'h1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        rx_bus.sin_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_valid", 32'(rx_bus.dout_valid), 32'h0);
        check("t5_rst_busy",  32'(rx_bus.busy),       32'h0);
        check("t5_rst_cnt",   32'(rx_bus.word_cnt),   32'h0);
        check("t5_rst_dout",  32'(rx_bus.dout),       32'h0);
        rx_bus.dout_ready = 1'b1;
        send_frame(1'b1, 4'b0011);
        check("t5_dout",  32'(rx_bus.dout),       32'h3);
        check("t5_valid", 32'(rx_bus.dout_valid), 32'h1);
        idle_cycle();
        check("t5_word_cnt", 32'(rx_bus.word_cnt), 32'h1);

`ifdef USR_SERIAL_RX_PARITY_EN
        // 6: even parity; 1010+0 is clean, 1011+0 is flagged
        send_frame(1'b1, 4'b1010);
        check("t6_wait_parity", 32'(rx_bus.dout_valid), 32'h0);
        send_bit(1'b1, 1'b0);
        check("t6a_dout", 32'(rx_bus.dout),       32'hA);
        check("t6a_perr", 32'(rx_bus.parity_err), 32'h0);
        send_frame(1'b1, 4'b1011);
        send_bit(1'b1, 1'b0);
        check("t6b_dout", 32'(rx_bus.dout),       32'hB);
        check("t6b_perr", 32'(rx_bus.parity_err), 32'h1);
        idle_cycle();
        check("t6_word_cnt", 32'(rx_bus.word_cnt), 32'h3);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_usr_serial_rx

`default_nettype wire

// File: doc/usr_serial_rx.md
Name: usr_serial_rx

Overview:
Serial-to-parallel receiver that reassembles WIDTH-bit words from a bit stream produced by a universal shift register. The source shifts left (MSB first) or right (LSB first). Sits at the far end of the shift-register datapath. Presents completed words on a valid/ready parallel port, backed by a one-word holding register.

Parameters:
WIDTH, 4, data word width in bits; legal range 2..32
CNT_W, 8, width of the delivered-word counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
sin_valid  in  1  serial bit present
sin_bit  in  1  serial data bit
sin_dir  in  1  bit order of the frame: 1 = MSB first (left-shift source), 0 = LSB first (right-shift source); sampled on the first bit of a frame only
sin_abort  in  1  discard the partial frame
sin_ready  out  1  receiver can accept a bit this cycle
dout  out  WIDTH  assembled word
dout_valid  out  1  dout holds an undelivered word
dout_ready  in  1  consumer accepts dout
parity_err  out  1  parity flag for the word on dout; valid while dout_valid is high
busy  out  1  frame in progress (state != IDLE)
word_cnt  out  CNT_W  count of delivered words; wraps modulo 2^CNT_W

Behaviour:
- Reset values, one cycle after rst is sampled high:
  - dout=0, dout_valid=0, parity_err=0, busy=0, word_cnt=0, sin_ready=1
  - accumulator and bit counter cleared
- rst overrides all other inputs. Reset mid-frame or with a held word discards both.
- A bit is accepted when sin_valid && sin_ready. sin_ready = !sin_abort && state != STALL.
- State IDLE:
  - An accepted bit latches dir_q=sin_dir, stores the bit, sets cnt=1 and moves to SHIFT.
- State SHIFT:
  - If dir_q=1: acc <= {acc[WIDTH-2:0], bit}.
  - If dir_q=0: acc <= {bit, acc[WIDTH-1:1]}.
  - When the WIDTH-th bit is accepted, the word is complete.
- Word completion:
  - If the holding register is empty, or is being drained this cycle (dout_valid && dout_ready), the word moves to dout. dout_valid is high the cycle after the last bit is accepted, so latency is 1 cycle. State returns to IDLE.
  - Otherwise the state moves to STALL with sin_ready=0. The word transfers to dout the cycle after the held word is handshaken, then the state returns to IDLE.
- Output handshake:
  - dout and parity_err stay stable while dout_valid && !dout_ready.
  - A handshake with no new word clears dout_valid.
  - A handshake and a completing word in the same cycle: dout_valid stays 1 and dout shows the new word.
  - word_cnt increments on each output handshake.
- sin_abort:
  - In SHIFT (or PARITY): the partial frame is discarded and the state goes to IDLE next cycle.
  - A bit offered in the same cycle is not accepted.
  - In IDLE: no effect. In STALL: ignored, the completed word is kept.
  - The holding register is never affected.
- The back-to-back stream runs at full rate: one bit per cycle with no bubble between frames, as long as the consumer keeps up.

Optional Feature:
Macro: USR_SERIAL_RX_PARITY_EN
- Defined:
  - After the WIDTH data bits, state PARITY accepts one extra bit.
  - Expected parity is even: XOR of the data bits and the parity bit equals 0.
  - parity_err = 1 on mismatch, registered together with dout.
  - Completion and latency are measured from the parity bit.
- Undefined:
  - There is no PARITY state and parity_err is tied to 0.
  - The port list is identical in both builds.

Decomposition:
- Package usr_serial_rx_pkg:
  - state enum: IDLE, SHIFT, PARITY, STALL
  - constants DIR_LSB_FIRST=1'b0 and DIR_MSB_FIRST=1'b1
- Sub-module usr_rx_shifter: direction-aware accumulator plus bit counter, with a load/clear/shift interface.
- The FSM and the holding register stay in the top module.

Test Plan:
1. WIDTH=4, sin_dir=1, bits 1,0,1,0 on consecutive cycles, dout_ready=1 -> dout=4'b1010, dout_valid for 1 cycle starting 1 cycle after the 4th bit, word_cnt=1.
2. sin_dir=0, bits 0,0,1,1 -> dout=4'b1100. Next, sin_dir=1, bits 1,1,0,0 -> dout=4'b1100, with no idle cycle between frames.
3. dout_ready=0, two frames 1010 then 0101 (MSB first) -> first word held. After the 8th bit, state is STALL and sin_ready=0. Raise dout_ready -> 1010 delivered, then 0101 appears next cycle. word_cnt reaches 2 once both are accepted.
4. After bits 1,1 of a frame, pulse sin_abort. Then send 0,1,1,0 MSB first -> dout=4'b0110. The aborted bits leave no trace, and busy=0 for 1 cycle after the abort.
5. rst asserted after 2 bits, with a word waiting on dout -> next cycle dout_valid=0, busy=0, word_cnt=0. A fresh frame 0011 then decodes correctly.
6. With the macro defined: bits 1,0,1,0 followed by parity 0 -> dout=1010, parity_err=0. Bits 1,0,1,1 followed by parity 0 -> parity_err=1.
